// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one combinational 8-bit ALU between NUM_REQ requesters. A
//   round-robin arbiter picks one valid request while idle, registers its
//   operands into the ALU, captures the ALU result one cycle later and holds
//   it as a tagged response until the consumer accepts it.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid / req_ready       per-requester handshake (ready is one-hot or 0)
//   req_ctrl / req_x / req_y    flattened payloads, requester i in slice i
//   alu_ctrl / alu_x / alu_y    registered operands driven to the ALU
//   alu_carry / alu_out         combinational ALU result
//   resp_valid / resp_ready     response handshake
//   resp_id                     index of the requester that issued the result
//   resp_out / resp_carry       captured ALU result
//   busy                        high while an operation is in flight
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [4*NUM_REQ-1:0] req_ctrl,
   input  logic [8*NUM_REQ-1:0] req_x,
   input  logic [8*NUM_REQ-1:0] req_y,
   output logic [3:0]           alu_ctrl,
   output logic [7:0]           alu_x,
   output logic [7:0]           alu_y,
   input  logic                 alu_carry,
   input  logic [7:0]           alu_out,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic [7:0]           resp_out,
   output logic                 resp_carry,
   output logic                 busy
);

   localparam int unsigned CTRL_W = 4;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    ptr_nxt;
   logic [ID_W-1:0]    grant_id;
   logic               grant_found;
   int unsigned        cand;

   logic               take;
   logic               capture;
   logic               resp_done;

   logic [CTRL_W-1:0]  ctrl_arr [NUM_REQ];
   logic [DATA_W-1:0]  x_arr    [NUM_REQ];
   logic [DATA_W-1:0]  y_arr    [NUM_REQ];

   // Unpack the flattened request buses into per-requester arrays
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign ctrl_arr[i] = req_ctrl[CTRL_W*i +: CTRL_W];
      assign x_arr[i]    = req_x[DATA_W*i +: DATA_W];
      assign y_arr[i]    = req_y[DATA_W*i +: DATA_W];
   end

   // Round-robin search: first valid requester starting at rr_ptr, wrapping
   always_comb begin : arbiter
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(rr_ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!grant_found && req_valid[ID_W'(cand)]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(cand);
         end
      end
   end

   // Pointer moves to the slot just after the winner
   always_comb begin : ptr_calc
      ptr_nxt = grant_id + ID_W'(1);
      if (32'(grant_id) == NUM_REQ - 1) begin
         ptr_nxt = '0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and control strobes; req_ready only ever rises in IDLE
   always_comb begin : fsm_next
      state_nxt = state;
      req_ready = '0;
      take      = 1'b0;
      capture   = 1'b0;
      resp_done = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               req_ready[grant_id] = 1'b1;
               take                = 1'b1;
               state_nxt           = EXEC;
            end
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (take) begin
         rr_ptr <= ptr_nxt;
      end
   end

   // ALU operand registers; hold between operations
   always_ff @(posedge clk or negedge rst_n) begin : alu_reg
      if (!rst_n) begin
         alu_ctrl <= '0;
         alu_x    <= '0;
         alu_y    <= '0;
      end else if (take) begin
         alu_ctrl <= ctrl_arr[grant_id];
         alu_x    <= x_arr[grant_id];
         alu_y    <= y_arr[grant_id];
      end
   end

   // Response tag, data and valid
   always_ff @(posedge clk or negedge rst_n) begin : resp_reg
      if (!rst_n) begin
         resp_id    <= '0;
         resp_out   <= '0;
         resp_carry <= 1'b0;
         resp_valid <= 1'b0;
      end else begin
         if (take) begin
            resp_id <= grant_id;
         end
         if (capture) begin
            resp_out   <= alu_out;
            resp_carry <= alu_carry;
            resp_valid <= 1'b1;
         end else if (resp_done) begin
            resp_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one combinational 8-bit ALU (4-bit ctrl, x, y in; carry, out back) between NUM_REQ requesters.
- Round-robin arbitration and valid/ready handshake on each request port.
- Registers the operands driven into the ALU and captures its result into a response register.
- Tags each response with the winning requester's index.
- Sits between the requesting datapath blocks and the single ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_ctrl  input  4*NUM_REQ  flattened ALU ctrl; requester i occupies bits [4i+3:4i]
req_x  input  8*NUM_REQ  flattened operand x; requester i occupies bits [8i+7:8i]
req_y  input  8*NUM_REQ  flattened operand y; same packing as req_x
alu_ctrl  output  4  registered ctrl to ALU
alu_x  output  8  registered x to ALU
alu_y  output  8  registered y to ALU
alu_carry  input  1  ALU carry result (combinational from alu_*)
alu_out  input  8  ALU data result
resp_valid  output  1  response valid
resp_ready  input  1  response consumer accept
resp_id  output  ID_W  index of requester that issued this result
resp_out  output  8  captured alu_out
resp_carry  output  1  captured alu_carry
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0; alu_ctrl/alu_x/alu_y=0; resp_valid=0, resp_id=0, resp_out=0, resp_carry=0. Outputs reach these values immediately, without waiting for a clock edge.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits=0.
  - On that edge: alu_ctrl/x/y <= slice g of req_ctrl/x/y; resp_id <= g; rr_ptr <= (g+1) mod NUM_REQ; state -> EXEC.
  - If no req_valid bit is high: stay in IDLE, all req_ready=0, registers unchanged.
- EXEC (exactly 1 cycle): resp_out <= alu_out; resp_carry <= alu_carry; resp_valid <= 1; state -> RESP.
- RESP:
  - Hold all resp_* stable.
  - On a cycle with resp_ready=1: resp_valid <= 0, state -> IDLE.
  - req_ready=0 throughout.
- req_ready is asserted only in IDLE. It never depends on resp_ready, so there is no combinational path from resp_ready to req_ready.
- Latency: acceptance edge T, resp_valid high after edge T+1, i.e. visible in cycle T+2.
- Minimum issue interval is 3 cycles when resp_ready is held high.
- alu_* registers hold their last values between operations; they change only on acceptance.
- Requester contract: hold valid and payload stable until ready. Dropping valid before ready is legal; the request is then simply not taken.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Reset asserted mid-operation (EXEC or RESP): the in-flight result is discarded, resp_valid drops immediately, rr_ptr returns to 0.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
- Reset mid-RESP: assert rst_n=0 while resp_valid=1 -> resp_valid=0, resp_out=0, busy=0 without a clock edge. After release, a req1 request is granted by the rr_ptr=0 search order.
- Single request: req_valid=4'b0001, req0 ctrl=4'b0000 x=8'h0F y=8'h01, resp_ready=1 -> req_ready=4'b0001 in cycle T. alu_x=8'h0F, alu_y=8'h01 after T. resp_valid in cycle T+2 with resp_id=0; resp_out/resp_carry equal the ALU's response to those operands.
- Round-robin, all four valid continuously, resp_ready=1 -> grant order 0,1,2,3,0; grants spaced exactly 3 cycles.
- Pointer skip: rr_ptr=2, req_valid=4'b0011 -> requester 0 granted, then rr_ptr=1.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* stable and req_ready=0 throughout. Release resp_ready -> next grant occurs in the cycle after the resp_ready handshake.
